// File: rtl/rmii_rx.sv
// rmii_rx : RMII 100 Mbps receive front end.
//
// Samples RXD1:0 / CRS_DV / RX_ER on REF_CLK, strips preamble and SFD,
// assembles LSB-first dibits into bytes and pushes them into the RX byte
// FIFO. The last byte of every frame carries fifo_EOD_in. Good and bad
// frame counts are exported gray-encoded for the host clock domain.
//
// Ports:
//   REF_CLK             50 MHz RMII reference clock (sole clock)
//   arst_n              asynchronous active-low reset
//   RXD0, RXD1          RMII receive dibit
//   CRS_DV              carrier sense / data valid
//   RX_ER               PHY receive error
//   fifo_full           FIFO write side full
//   fifo_wren           FIFO write strobe (registered)
//   fifo_din[7:0]       FIFO write data (registered)
//   fifo_EOD_in         last byte of frame, valid with fifo_wren
//   fifo_ERR_in         bad/overflowed frame marker, valid with fifo_wren
//                       (present only when RMII_RX_ERR_FLAG_EN is defined)
//   succ_rx_count_gray  good frame count, gray-encoded
//   fail_rx_count_gray  bad frame count, gray-encoded
//
// Build option: define RMII_RX_ERR_FLAG_EN to add the fifo_ERR_in output.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no frame; waiting for crs=1 with a 01 preamble dibit
// S_PREAMBLE | counting preamble dibits, waiting for the 11 SFD dibit
// S_BODY     | assembling bytes; one byte held back to tag EOD on it
// S_DROP     | discarding input until end of carrier
// S_OVF      | FIFO was full; waiting to write the held byte with EOD
module rmii_rx #(
    parameter int MAX_PREAMBLE = 63,
    parameter int MAX_BYTES    = 1522
) (
    input  logic        REF_CLK,
    input  logic        arst_n,
    input  logic        RXD0,
    input  logic        RXD1,
    input  logic        CRS_DV,
    input  logic        RX_ER,
    input  logic        fifo_full,
    output logic        fifo_wren,
    output logic [7:0]  fifo_din,
    output logic        fifo_EOD_in,
`ifdef RMII_RX_ERR_FLAG_EN
    output logic        fifo_ERR_in,
`endif
    output logic [15:0] succ_rx_count_gray,
    output logic [15:0] fail_rx_count_gray
);

    localparam int PW = $clog2(MAX_PREAMBLE + 1);
    localparam int BW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_BODY,
        S_DROP,
        S_OVF
    } state_t;

    // s1 is the registered pin sample; s2 is one dibit older. A dibit is
    // judged in s2 so that the following crs value is already known.
    logic [1:0]    d_s1, d_s2;
    logic          crs_s1, crs_s2;
    logic          er_s1, er_s2;

    state_t        state;
    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] byte_cnt;
    logic [1:0]    dibit_idx;
    logic [5:0]    byte_sr;
    logic [7:0]    hold_byte;
    logic          eoc_seen;
    logic [15:0]   succ_cnt;
    logic [15:0]   fail_cnt;

    logic          eoc;
    logic          trunc;
    logic [7:0]    new_byte;

    // Two consecutive crs=0 samples end the carrier; a lone crs=0 followed
    // by crs=1 is the CRS_DV toggle and the dibit in s2 is still data.
    assign eoc      = !crs_s2 && !crs_s1;
    assign trunc    = (dibit_idx == 2'd3) && (byte_cnt == BW'(MAX_BYTES));
    assign new_byte = {d_s2, byte_sr};

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            d_s1   <= '0;
            crs_s1 <= 1'b0;
            er_s1  <= 1'b0;
            d_s2   <= '0;
            crs_s2 <= 1'b0;
            er_s2  <= 1'b0;
        end else begin
            d_s1   <= {RXD1, RXD0};
            crs_s1 <= CRS_DV;
            er_s1  <= RX_ER;
            d_s2   <= d_s1;
            crs_s2 <= crs_s1;
            er_s2  <= er_s1;
        end
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            byte_cnt    <= '0;
            dibit_idx   <= '0;
            byte_sr     <= '0;
            hold_byte   <= '0;
            eoc_seen    <= 1'b0;
            succ_cnt    <= '0;
            fail_cnt    <= '0;
            fifo_wren   <= 1'b0;
            fifo_din    <= '0;
            fifo_EOD_in <= 1'b0;
`ifdef RMII_RX_ERR_FLAG_EN
            fifo_ERR_in <= 1'b0;
`endif
        end else begin
            fifo_wren   <= 1'b0;
            fifo_EOD_in <= 1'b0;
`ifdef RMII_RX_ERR_FLAG_EN
            fifo_ERR_in <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (crs_s2 && d_s2 == 2'b01) begin
                        state   <= S_PREAMBLE;
                        pre_cnt <= '0;
                    end
                end

                // pre_cnt counts non-SFD dibits seen inside S_PREAMBLE; the
                // MAX_PREAMBLE-th one drops the frame.
                S_PREAMBLE: begin
                    if (eoc) begin
                        state <= S_IDLE;
                    end else begin
                        case (d_s2)
                            2'b11: begin
                                state     <= S_BODY;
                                byte_cnt  <= '0;
                                dibit_idx <= '0;
                            end
                            2'b10: state <= S_DROP;
                            default: begin
                                if (pre_cnt == PW'(MAX_PREAMBLE - 1))
                                    state <= S_DROP;
                                else
                                    pre_cnt <= pre_cnt + 1'b1;
                            end
                        endcase
                    end
                end

                S_BODY: begin
                    if (eoc || (crs_s2 && er_s2) || trunc) begin
                        // Frame ends here; the in-progress byte is discarded.
                        if (byte_cnt == '0) begin
                            fail_cnt <= fail_cnt + 16'd1;
                            state    <= eoc ? S_IDLE : S_DROP;
                        end else if (fifo_full) begin
                            fail_cnt <= fail_cnt + 16'd1;
                            eoc_seen <= eoc;
                            state    <= S_OVF;
                        end else begin
                            fifo_wren   <= 1'b1;
                            fifo_din    <= hold_byte;
                            fifo_EOD_in <= 1'b1;
                            if (eoc && dibit_idx == 2'd0) begin
                                succ_cnt <= succ_cnt + 16'd1;
                            end else begin
                                fail_cnt <= fail_cnt + 16'd1;
`ifdef RMII_RX_ERR_FLAG_EN
                                fifo_ERR_in <= 1'b1;
`endif
                            end
                            state <= eoc ? S_IDLE : S_DROP;
                        end
                    end else begin
                        dibit_idx <= dibit_idx + 2'd1;
                        case (dibit_idx)
                            2'd0: byte_sr[1:0] <= d_s2;
                            2'd1: byte_sr[3:2] <= d_s2;
                            2'd2: byte_sr[5:4] <= d_s2;
                            default: begin
                                byte_cnt <= byte_cnt + 1'b1;
                                if (byte_cnt == '0) begin
                                    hold_byte <= new_byte;
                                end else if (fifo_full) begin
                                    // Keep the older byte so it can close
                                    // the frame once the FIFO drains.
                                    fail_cnt <= fail_cnt + 16'd1;
                                    eoc_seen <= 1'b0;
                                    state    <= S_OVF;
                                end else begin
                                    fifo_wren <= 1'b1;
                                    fifo_din  <= hold_byte;
                                    hold_byte <= new_byte;
                                end
                            end
                        endcase
                    end
                end

                S_DROP: begin
                    if (eoc)
                        state <= S_IDLE;
                end

                S_OVF: begin
                    if (eoc)
                        eoc_seen <= 1'b1;
                    if (!fifo_full) begin
                        fifo_wren   <= 1'b1;
                        fifo_din    <= hold_byte;
                        fifo_EOD_in <= 1'b1;
`ifdef RMII_RX_ERR_FLAG_EN
                        fifo_ERR_in <= 1'b1;
`endif
                        state <= (eoc_seen || eoc) ? S_IDLE : S_DROP;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            succ_rx_count_gray <= '0;
            fail_rx_count_gray <= '0;
        end else begin
            succ_rx_count_gray <= succ_cnt ^ (succ_cnt >> 1);
            fail_rx_count_gray <= fail_cnt ^ (fail_cnt >> 1);
        end
    end

endmodule

// File: tb/tb_rmii_rx.sv
// tb_rmii_rx : self-checking bench for rmii_rx. Expected FIFO writes are
// queued as frames are driven and compared when the DUT writes.
module tb_rmii_rx;

    localparam int MAXB = 1522;

    logic        REF_CLK;
    logic        arst_n;
    logic        RXD0, RXD1, CRS_DV, RX_ER, fifo_full;
    logic        fifo_wren;
    logic [7:0]  fifo_din;
    logic        fifo_EOD_in;
`ifdef RMII_RX_ERR_FLAG_EN
    logic        fifo_ERR_in;
`endif
    logic [15:0] succ_rx_count_gray;
    logic [15:0] fail_rx_count_gray;

    rmii_rx #(.MAX_PREAMBLE(63), .MAX_BYTES(MAXB)) dut (
        .REF_CLK            (REF_CLK),
        .arst_n             (arst_n),
        .RXD0               (RXD0),
        .RXD1               (RXD1),
        .CRS_DV             (CRS_DV),
        .RX_ER              (RX_ER),
        .fifo_full          (fifo_full),
        .fifo_wren          (fifo_wren),
        .fifo_din           (fifo_din),
        .fifo_EOD_in        (fifo_EOD_in),
`ifdef RMII_RX_ERR_FLAG_EN
        .fifo_ERR_in        (fifo_ERR_in),
`endif
        .succ_rx_count_gray (succ_rx_count_gray),
        .fail_rx_count_gray (fail_rx_count_gray)
    );

    initial REF_CLK = 1'b0;
    always #10 REF_CLK = ~REF_CLK;

    typedef struct packed {
        logic [7:0] din;
        logic       eod;
        logic       err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_succ = '0;
    logic [15:0] exp_fail = '0;

    function automatic logic [15:0] to_gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    task automatic expect_wr(input logic [7:0] d, input logic eod, input logic err);
        exp_t e;
        e.din = d;
        e.eod = eod;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic [1:0] d, input logic c, input logic e);
        RXD1   = d[1];
        RXD0   = d[0];
        CRS_DV = c;
        RX_ER  = e;
        @(negedge REF_CLK);
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) drv(2'b01, 1'b1, 1'b0);
        drv(2'b11, 1'b1, 1'b0);
    endtask

    // tog: CRS_DV follows 0,1,0,1 across the dibits; er_at: dibit with RX_ER
    task automatic send_byte(input logic [7:0] b, input logic tog, input int er_at);
        logic c;
        for (int k = 0; k < 4; k++) begin
            c = tog ? ((k % 2) == 1) : 1'b1;
            drv(b[2*k +: 2], c, (k == er_at));
        end
    endtask

    task automatic end_frame();
        for (int i = 0; i < 8; i++) drv(2'b00, 1'b0, 1'b0);
    endtask

    task automatic check_end(input string tag);
        chk({tag, ":drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, ":succ"}, 32'(succ_rx_count_gray), 32'(to_gray(exp_succ)));
        chk({tag, ":fail"}, 32'(fail_rx_count_gray), 32'(to_gray(exp_fail)));
    endtask

    always @(negedge REF_CLK) begin : monitor
        exp_t e;
        if (fifo_wren) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_data", 32'(fifo_din), 32'(e.din));
                chk("wr_eod", 32'(fifo_EOD_in), 32'(e.eod));
`ifdef RMII_RX_ERR_FLAG_EN
                chk("wr_err", 32'(fifo_ERR_in), 32'(e.err));
`endif
            end
        end
    end

    initial begin
        int w;
        arst_n = 1'b0;
        RXD0 = 1'b0; RXD1 = 1'b0; CRS_DV = 1'b0; RX_ER = 1'b0; fifo_full = 1'b0;
        repeat (3) @(negedge REF_CLK);
        chk("rst_wren", 32'(fifo_wren), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);
        chk("rst_eod", 32'(fifo_EOD_in), 32'd0);
`ifdef RMII_RX_ERR_FLAG_EN
        chk("rst_err", 32'(fifo_ERR_in), 32'd0);
`endif
        chk("rst_succ", 32'(succ_rx_count_gray), 32'd0);
        chk("rst_fail", 32'(fail_rx_count_gray), 32'd0);
        arst_n = 1'b1;
        repeat (2) @(negedge REF_CLK);

        // good 3-byte frame
        expect_wr(8'h55, 0, 0); expect_wr(8'hAA, 0, 0); expect_wr(8'h0F, 1, 0);
        preamble(31);
        send_byte(8'h55, 0, -1); send_byte(8'hAA, 0, -1); send_byte(8'h0F, 0, -1);
        end_frame();
        exp_succ = exp_succ + 16'd1;
        check_end("good");

        // CRS_DV toggling over the last two bytes
        expect_wr(8'h11, 0, 0); expect_wr(8'h22, 0, 0);
        expect_wr(8'h33, 0, 0); expect_wr(8'h44, 1, 0);
        preamble(31);
        send_byte(8'h11, 0, -1); send_byte(8'h22, 0, -1);
        send_byte(8'h33, 1, -1); send_byte(8'h44, 1, -1);
        end_frame();
        exp_succ = exp_succ + 16'd1;
        check_end("toggle");

        // carrier lost mid-byte
        expect_wr(8'hA1, 0, 0); expect_wr(8'hB2, 1, 1);
        preamble(31);
        send_byte(8'hA1, 0, -1); send_byte(8'hB2, 0, -1);
        drv(2'b10, 1, 0); drv(2'b01, 1, 0);
        end_frame();
        exp_fail = exp_fail + 16'd1;
        check_end("partial");

        // RX_ER inside the body
        expect_wr(8'hC3, 1, 1);
        preamble(31);
        send_byte(8'hC3, 0, -1); send_byte(8'h5D, 0, 1); send_byte(8'h77, 0, -1);
        end_frame();
        exp_fail = exp_fail + 16'd1;
        check_end("rx_er");

        // SFD immediately followed by end of carrier
        preamble(31);
        end_frame();
        exp_fail = exp_fail + 16'd1;
        check_end("zero_byte");

        // illegal 10 dibit in the preamble
        for (int i = 0; i < 10; i++) drv(2'b01, 1, 0);
        drv(2'b10, 1, 0);
        preamble(10);
        send_byte(8'h99, 0, -1);
        end_frame();
        check_end("pre_10");

        // preamble length boundary: 1 entry + 62 dibits is accepted
        expect_wr(8'h6B, 1, 0);
        preamble(63);
        send_byte(8'h6B, 0, -1);
        end_frame();
        exp_succ = exp_succ + 16'd1;
        check_end("pre_max_ok");

        // 1 entry + 63 dibits exceeds the limit
        preamble(64);
        send_byte(8'h6C, 0, -1);
        end_frame();
        check_end("pre_max_drop");

        // FIFO full while byte 2 is held
        expect_wr(8'h01, 0, 0); expect_wr(8'h02, 1, 1);
        fork
            begin
                w = 0;
                while (!fifo_wren && w < 200) begin
                    @(negedge REF_CLK);
                    w++;
                end
                chk("full_trigger_seen", 32'(fifo_wren), 32'd1);
                fifo_full = 1'b1;
                repeat (10) @(negedge REF_CLK);
                fifo_full = 1'b0;
            end
        join_none
        preamble(31);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 0, -1);
        end_frame();
        exp_fail = exp_fail + 16'd1;
        check_end("overflow");

        expect_wr(8'h5A, 0, 0); expect_wr(8'hA5, 1, 0);
        preamble(31);
        send_byte(8'h5A, 0, -1); send_byte(8'hA5, 0, -1);
        end_frame();
        exp_succ = exp_succ + 16'd1;
        check_end("after_ovf");

        // truncation at MAX_BYTES
        for (int i = 1; i <= MAXB; i++)
            expect_wr(8'(i), (i == MAXB), (i == MAXB));
        preamble(31);
        for (int i = 1; i <= MAXB + 2; i++) send_byte(8'(i), 0, -1);
        end_frame();
        exp_fail = exp_fail + 16'd1;
        check_end("trunc");

        // asynchronous reset mid-frame
        preamble(31);
        send_byte(8'h81, 0, -1);
        drv(2'b10, 1, 0); drv(2'b01, 1, 0);
        #5 arst_n = 1'b0;
        #1;
        chk("arst_wren", 32'(fifo_wren), 32'd0);
        chk("arst_din", 32'(fifo_din), 32'd0);
        chk("arst_succ", 32'(succ_rx_count_gray), 32'd0);
        chk("arst_fail", 32'(fail_rx_count_gray), 32'd0);
        @(negedge REF_CLK);
        CRS_DV = 1'b0; RXD0 = 1'b0; RXD1 = 1'b0;
        repeat (2) @(negedge REF_CLK);
        arst_n = 1'b1;
        exp_succ = '0;
        exp_fail = '0;
        @(negedge REF_CLK);

        // 00 noise with carrier up must not start a frame
        for (int i = 0; i < 8; i++) drv(2'b00, 1, 0);
        end_frame();
        check_end("noise");

        expect_wr(8'h7E, 1, 0);
        preamble(31);
        send_byte(8'h7E, 0, -1);
        end_frame();
        exp_succ = exp_succ + 16'd1;
        check_end("post_reset");

        // good counter wrap
        force dut.succ_cnt = 16'hFFFF;
        repeat (2) @(negedge REF_CLK);
        release dut.succ_cnt;
        @(negedge REF_CLK);
        exp_succ = 16'hFFFF;
        chk("preload_gray", 32'(succ_rx_count_gray), 32'(to_gray(exp_succ)));
        expect_wr(8'h3C, 1, 0);
        preamble(31);
        send_byte(8'h3C, 0, -1);
        end_frame();
        exp_succ = exp_succ + 16'd1;
        check_end("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
